fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage directly upstream of the main decoder in the RISC-V core. Holds the program counter, issues word reads to instruction memory over a valid/ready request plus valid response interface, and registers the returned instruction. It presents the instruction to the decode stage, which takes `op` from `instr[6:0]`. When decode accepts the instruction, the unit samples the branch decision (`pc_src`) and target, and selects the next PC.

## Interface
- `N`, 32, address/PC width
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- `clk` in 1: single clock, all state updates on the rising edge
- `rst` in 1: reset, asynchronous, active-high
- `imem_req_valid` out 1: fetch request valid
- `imem_req_ready` in 1: instruction memory accepts the request
- `imem_addr` out N: fetch address, equal to `pc`
- `imem_rsp_valid` in 1: read data valid
- `imem_rsp_data` in 32: fetched instruction word
- `instr` out 32: registered instruction, feeds the decoder
- `instr_valid` out 1: `instr` holds a new instruction
- `instr_ready` in 1: decode/execute consumes `instr` this cycle
- `pc` out N: address of the current instruction
- `pc_plus4` out N: `pc + 4`
- `pc_src` in 1: decoder's Branch & zero, i.e. take the branch
- `pc_target` in N: branch target from the PC-relative adder

## Operation
- FSM states: IDLE, FETCH, WAIT, ISSUE.
- IDLE:
  - Entered only on reset.
  - Unconditionally moves to FETCH on the next edge.
- FETCH:
  - `imem_req_valid`=1 and `imem_addr`=`pc`.
  - On `imem_req_ready`=1, moves to WAIT.
  - Otherwise stays in FETCH, with the request and address held stable.
- WAIT:
  - On `imem_rsp_valid`=1, loads `instr` from `imem_rsp_data` and moves to ISSUE.
  - `imem_rsp_valid` is ignored in every other state.
- ISSUE:
  - `instr_valid`=1, with `instr` and `pc` held stable.
  - On `instr_ready`=1, the next PC is `pc_target` with bits [1:0] forced to 0 if `pc_src`=1, else `pc_plus4`. The new PC is written and the FSM moves to FETCH.
  - `pc_src` and `pc_target` are sampled only in this handshake cycle and are don't-care otherwise.
- PC arithmetic is modulo 2^N: `pc`=2^N-4 wraps to 0 through `pc_plus4`.
- `instr` is not cleared on handshake. It keeps its last value until the next response.
- Only one request is outstanding at a time; there is no prefetch.

## Timing
- Reset values:
  - state IDLE
  - `pc`=`RESET_PC`, `pc_plus4`=`RESET_PC`+4
  - `instr`=32'h0000_0013 (NOP)
  - `instr_valid`=0, `imem_req_valid`=0
- First request is driven the cycle after `rst` deasserts.
- Minimum cycles per instruction is 3 (FETCH, WAIT, ISSUE), with zero-wait memory and `instr_ready` held high.
- `imem_req_valid`, `instr_valid` and `imem_addr` are decoded from registered state only. They have no combinational path from any input.
- `pc_plus4` is combinational from `pc`.
- `rst` asserted mid-operation, in any state:
  - All registers return to reset values immediately, without waiting for a clock edge.
  - An in-flight memory response arriving after reset is discarded, because the FSM is not in WAIT.

## Structure
- Shared package `rv_pkg`:
  - FSM state enum `fetch_state_t`
  - constant `NOP_INSTR`=32'h0000_0013
  - default reset-vector constant
  - opcode constants already used by the decoder
- Sub-module `pc_next`: combinational. Computes `pc_plus4` and the next-PC mux from `pc`, `pc_src` and `pc_target`, including alignment masking.
- Top level: FSM, PC register and instruction register.

## Test plan
- **Reset release:** `RESET_PC`=0, memory always ready, rsp_data 32'h00500093, `instr_ready`=1.
  - First `imem_req_valid` appears 1 cycle after reset release, with `imem_addr`=0.
  - `instr`=32'h00500093 and `instr_valid`=1 two cycles later.
  - Next address is 4.
- **Sequential run:** 4 instructions, no branch.
  - Addresses 0, 4, 8, 12, each spaced exactly 3 cycles apart.
- **Taken branch:** in ISSUE at `pc`=8, with `pc_src`=1 and `pc_target`=32'h0000_0022.
  - Next `imem_addr`=32'h0000_0020.
- **Backpressure:**
  - Holding `imem_req_ready` low for 5 cycles keeps `imem_addr` stable at its value.
  - Holding `instr_ready` low for 4 cycles keeps `instr`, `pc` and `instr_valid`=1 unchanged.
  - `pc_src` toggles during the stall and has no effect.
- **Wrap-around:** `RESET_PC`=32'hFFFF_FFFC with no branch.
  - Second fetch address is 0.
- **Mid-operation reset:** `rst` pulsed asynchronously while in WAIT at `pc`=12, then `imem_rsp_valid` arrives.
  - Outputs return to reset values immediately.
  - The late response is ignored, `instr`=NOP, and the next fetch is from `RESET_PC`.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared RISC-V core definitions: fetch FSM states, reset vector, NOP and the
// major opcodes the decoder switches on.
package rv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WAIT  = 2'd2,
        ISSUE = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

endpackage

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and the decode stage.
//
// Handshakes: a request transfers on an edge where imem_req_valid and
// imem_req_ready are both high; the requester holds valid and address stable
// until then. The response has no ready: imem_rsp_valid is a one-cycle pulse
// the fetch unit must take. The instruction transfers to decode on an edge
// where instr_valid and instr_ready are both high; instr and pc stay stable
// until then, and pc_src/pc_target are only meaningful on that edge.
interface fetch_unit_if #(
    parameter int N = 32
);
    logic         imem_req_valid;
    logic         imem_req_ready;
    logic [N-1:0] imem_addr;
    logic         imem_rsp_valid;
    logic [31:0]  imem_rsp_data;
    logic [31:0]  instr;
    logic         instr_valid;
    logic         instr_ready;
    logic [N-1:0] pc;
    logic [N-1:0] pc_plus4;
    logic         pc_src;
    logic [N-1:0] pc_target;

    modport master (
        output imem_req_valid,
        output imem_addr,
        output instr,
        output instr_valid,
        output pc,
        output pc_plus4,
        input  imem_req_ready,
        input  imem_rsp_valid,
        input  imem_rsp_data,
        input  instr_ready,
        input  pc_src,
        input  pc_target
    );

    modport slave (
        input  imem_req_valid,
        input  imem_addr,
        input  instr,
        input  instr_valid,
        input  pc,
        input  pc_plus4,
        output imem_req_ready,
        output imem_rsp_valid,
        output imem_rsp_data,
        output instr_ready,
        output pc_src,
        output pc_target
    );

endinterface

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selection: sequential pc+4 or the branch target forced to a word
// boundary. Purely combinational, wraps modulo 2^N.
module pc_next #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_pc,
    input  logic         i_pc_src,
    input  logic [N-1:0] i_pc_target,
    output logic [N-1:0] o_pc_plus4,
    output logic [N-1:0] o_pc_next
);

    localparam logic [N-1:0] ALIGN_MASK = {{(N-2){1'b1}}, 2'b00};

    logic [N-1:0] w_target_aligned;

    assign o_pc_plus4       = i_pc + N'(4);
    assign w_target_aligned = i_pc_target & ALIGN_MASK;
    assign o_pc_next        = i_pc_src ? w_target_aligned : o_pc_plus4;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time and
// holds the returned instruction until decode accepts it.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int           N        = 32,
    parameter logic [N-1:0] RESET_PC = N'(DEFAULT_RESET_PC)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus,
    output fetch_state_t o_dbg_state
);

    fetch_state_t r_state;
    logic [N-1:0] r_pc;
    logic [31:0]  r_instr;
    logic         r_req_valid;
    logic         r_instr_valid;

    logic [N-1:0] w_pc_plus4;
    logic [N-1:0] w_pc_next;

    pc_next #(
        .N(N)
    ) u_pc_next (
        .i_pc        (r_pc),
        .i_pc_src    (bus.pc_src),
        .i_pc_target (bus.pc_target),
        .o_pc_plus4  (w_pc_plus4),
        .o_pc_next   (w_pc_next)
    );

    // Valid flags are registered alongside the state so no input reaches them
    // combinationally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_pc          <= RESET_PC;
            r_instr       <= NOP_INSTR;
            r_req_valid   <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_state     <= FETCH;
                    r_req_valid <= 1'b1;
                end
                FETCH: begin
                    if (bus.imem_req_ready) begin
                        r_state     <= WAIT;
                        r_req_valid <= 1'b0;
                    end
                end
                WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        r_instr       <= bus.imem_rsp_data;
                        r_state       <= ISSUE;
                        r_instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (bus.instr_ready) begin
                        r_pc          <= w_pc_next;
                        r_state       <= FETCH;
                        r_instr_valid <= 1'b0;
                        r_req_valid   <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_req_valid   <= 1'b0;
                    r_instr_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req_valid = r_req_valid;
    assign bus.imem_addr      = r_pc;
    assign bus.instr          = r_instr;
    assign bus.instr_valid    = r_instr_valid;
    assign bus.pc             = r_pc;
    assign bus.pc_plus4       = w_pc_plus4;
    assign o_dbg_state        = r_state;

endmodule
